// File: rtl/network_consts_pkg.sv
// Network-wide widths, probe message encodings and the output-slot state type
// shared by the probe channel arbiter and its selector.
package network_consts_pkg;

   localparam int SRC_W   = 2;
   localparam int ADDR_W  = 26;
   localparam int PTYPE_W = 2;

   typedef enum logic [PTYPE_W-1:0] {
      P_PROBE_INVALIDATE = 2'd0,
      P_PROBE_COPY       = 2'd1,
      P_PROBE_DOWNGRADE  = 2'd2
   } p_type_e;

   typedef enum logic [0:0] {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: first requester at or after rr_ptr wins.
module rr_select #(
   parameter int N_CLIENTS = 2,
   parameter int IDX_W     = $clog2(N_CLIENTS)
) (
   input  logic [N_CLIENTS-1:0] req,
   input  logic [IDX_W-1:0]     rr_ptr,
   output logic [N_CLIENTS-1:0] grant,
   output logic [IDX_W-1:0]     idx,
   output logic                 any
);

   localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_CLIENTS);

   // Walk the ring from rr_ptr; once a grant is taken later requesters are masked.
   always_comb begin
      logic [IDX_W:0]   sum_s;
      logic [IDX_W-1:0] pos_s;
      logic             take_s;
      grant  = '0;
      idx    = rr_ptr;
      any    = 1'b0;
      sum_s  = '0;
      pos_s  = '0;
      take_s = 1'b0;
      for (int k = 0; k < N_CLIENTS; k++) begin
         sum_s       = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         sum_s       = (sum_s >= N_L) ? (sum_s - N_L) : sum_s;
         pos_s       = sum_s[IDX_W-1:0];
         take_s      = req[pos_s] & ~any;
         grant[pos_s] = grant[pos_s] | take_s;
         idx         = take_s ? pos_s : idx;
         any         = any | take_s;
      end
   end

endmodule

// File: rtl/probe_channel_arbiter.sv
// Round-robin arbiter sharing one probe/release channel among N_CLIENTS sources,
// stamping header_src with the winner's network ID into a single-entry output slot.
module probe_channel_arbiter
   import network_consts_pkg::*;
#(
   parameter int N_CLIENTS = 2,
   parameter int SRC_W     = network_consts_pkg::SRC_W,
   parameter int ADDR_W    = network_consts_pkg::ADDR_W,
   parameter int PTYPE_W   = network_consts_pkg::PTYPE_W,
   parameter int SRC_BASE  = 0,
   parameter int IDX_W     = $clog2(N_CLIENTS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_CLIENTS-1:0]         io_in_valid,
   output logic [N_CLIENTS-1:0]         io_in_ready,
   input  logic [N_CLIENTS*SRC_W-1:0]   io_in_bits_header_dst,
   input  logic [N_CLIENTS*ADDR_W-1:0]  io_in_bits_payload_addr_block,
   input  logic [N_CLIENTS*PTYPE_W-1:0] io_in_bits_payload_p_type,
   input  logic                         io_out_ready,
   output logic                         io_out_valid,
   output logic [SRC_W-1:0]             io_out_bits_header_src,
   output logic [SRC_W-1:0]             io_out_bits_header_dst,
   output logic [ADDR_W-1:0]            io_out_bits_payload_addr_block,
   output logic [PTYPE_W-1:0]           io_out_bits_payload_p_type,
   output logic [IDX_W-1:0]             io_chosen
);

   slot_state_e          state_r, state_nxt_s;
   logic                 full_s;
   logic [IDX_W-1:0]     rr_ptr_r;
   logic [N_CLIENTS-1:0] grant_s;
   logic [IDX_W-1:0]     idx_s;
   logic                 any_s, can_acc_s, enq_s, deq_s;
   logic [SRC_W-1:0]     dst_s, src_r, dst_r;
   logic [ADDR_W-1:0]    addr_s, addr_r;
   logic [PTYPE_W-1:0]   ptype_s, ptype_r;

   rr_select #(.N_CLIENTS(N_CLIENTS), .IDX_W(IDX_W)) u_rr_select (
      .req    (io_in_valid),
      .rr_ptr (rr_ptr_r),
      .grant  (grant_s),
      .idx    (idx_s),
      .any    (any_s)
   );

   // Handshake: a full slot still accepts when it drains this cycle; reset blocks grants at once.
   always_comb begin
      can_acc_s   = ~full_s | io_out_ready;
      io_in_ready = (can_acc_s & any_s & ~reset) ? grant_s : '0;
      enq_s       = |(io_in_valid & io_in_ready);
      deq_s       = full_s & io_out_ready;
      io_chosen   = idx_s;
   end

   // Winner's fields, picked by AND-OR over the one-hot grant.
   always_comb begin
      dst_s   = '0;
      addr_s  = '0;
      ptype_s = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         dst_s   = dst_s   | ({SRC_W{grant_s[i]}}   & io_in_bits_header_dst[i*SRC_W +: SRC_W]);
         addr_s  = addr_s  | ({ADDR_W{grant_s[i]}}  & io_in_bits_payload_addr_block[i*ADDR_W +: ADDR_W]);
         ptype_s = ptype_s | ({PTYPE_W{grant_s[i]}} & io_in_bits_payload_p_type[i*PTYPE_W +: PTYPE_W]);
      end
   end

   // Slot state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= SLOT_EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Slot next state: fill on enq, drain only when nothing refills it.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         SLOT_EMPTY: state_nxt_s = enq_s ? SLOT_FULL : SLOT_EMPTY;
         SLOT_FULL:  state_nxt_s = (deq_s & ~enq_s) ? SLOT_EMPTY : SLOT_FULL;
         default:    state_nxt_s = SLOT_EMPTY;
      endcase
   end

   // Slot state decode.
   always_comb begin
      full_s = 1'b0;
      case (state_r)
         SLOT_EMPTY: full_s = 1'b0;
         SLOT_FULL:  full_s = 1'b1;
         default:    full_s = 1'b0;
      endcase
      io_out_valid = full_s;
   end

   // Round-robin pointer advances past the winner on every enq.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_r <= '0;
      end else if (enq_s) begin
         rr_ptr_r <= (idx_s == IDX_W'(N_CLIENTS-1)) ? '0 : idx_s + IDX_W'(1);
      end
   end

   // Slot data carries no reset; it is only meaningful while the slot is full.
   always_ff @(posedge clk) begin
      if (enq_s) begin
         src_r   <= SRC_W'(SRC_BASE) + SRC_W'(idx_s);
         dst_r   <= dst_s;
         addr_r  <= addr_s;
         ptype_r <= ptype_s;
      end
   end

   assign io_out_bits_header_src         = src_r;
   assign io_out_bits_header_dst         = dst_r;
   assign io_out_bits_payload_addr_block = addr_r;
   assign io_out_bits_payload_p_type     = ptype_r;

endmodule

// File: tb/tb_probe_channel_arbiter.sv
// Directed bench for probe_channel_arbiter: a 2-client instance and a
// 4-client instance with SRC_BASE=1 for pointer wrap.
module tb_probe_channel_arbiter;
   import network_consts_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [1:0]  v2, rdy2;
   logic [3:0]  dst2, pt2;
   logic [51:0] addr2;
   logic        ordy2, oval2;
   logic [1:0]  osrc2, odst2, opt2;
   logic [25:0] oaddr2;
   logic [0:0]  ch2;

   logic [3:0]   v4, rdy4;
   logic [11:0]  dst4;
   logic [103:0] addr4;
   logic [7:0]   pt4;
   logic         ordy4, oval4;
   logic [2:0]   osrc4, odst4;
   logic [25:0]  oaddr4;
   logic [1:0]   opt4, ch4;

   always #5 clk = ~clk;

   probe_channel_arbiter #(.N_CLIENTS(2), .SRC_W(2), .SRC_BASE(0)) dut2 (
      .clk(clk), .reset(reset),
      .io_in_valid(v2), .io_in_ready(rdy2),
      .io_in_bits_header_dst(dst2), .io_in_bits_payload_addr_block(addr2),
      .io_in_bits_payload_p_type(pt2), .io_out_ready(ordy2), .io_out_valid(oval2),
      .io_out_bits_header_src(osrc2), .io_out_bits_header_dst(odst2),
      .io_out_bits_payload_addr_block(oaddr2), .io_out_bits_payload_p_type(opt2),
      .io_chosen(ch2)
   );

   probe_channel_arbiter #(.N_CLIENTS(4), .SRC_W(3), .SRC_BASE(1)) dut4 (
      .clk(clk), .reset(reset),
      .io_in_valid(v4), .io_in_ready(rdy4),
      .io_in_bits_header_dst(dst4), .io_in_bits_payload_addr_block(addr4),
      .io_in_bits_payload_p_type(pt4), .io_out_ready(ordy4), .io_out_valid(oval4),
      .io_out_bits_header_src(osrc4), .io_out_bits_header_dst(odst4),
      .io_out_bits_payload_addr_block(oaddr4), .io_out_bits_payload_p_type(opt4),
      .io_chosen(ch4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      v2 = 2'b11; ordy2 = 1'b1;
      #1;
      checks++; if (rdy2 !== 2'b00) begin errors++; $display("FAIL reset_in_ready got %b expected 00", rdy2); end
      checks++; if (oval2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid2 got %b expected 0", oval2); end
      checks++; if (oval4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid4 got %b expected 0", oval4); end
      @(posedge clk); #1 reset = 1'b0;
      #1;
      checks++; if (rdy2 !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b expected 01", rdy2); end
      checks++; if (ch2 !== 1'b0) begin errors++; $display("FAIL reset_chosen got %0d expected 0", ch2); end
      v2 = 2'b00;
   endtask

   task automatic test_single();
      dst2[3:2] = 2'd2; addr2[51:26] = 26'h0ABCDEF; pt2[3:2] = P_PROBE_COPY;
      v2 = 2'b10; ordy2 = 1'b1;
      #1;
      checks++; if (rdy2 !== 2'b10) begin errors++; $display("FAIL single_in_ready got %b expected 10", rdy2); end
      tick();
      v2 = 2'b00;
      checks++; if (oval2 !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b expected 1", oval2); end
      checks++; if (osrc2 !== 2'd1) begin errors++; $display("FAIL single_src got %0d expected 1", osrc2); end
      checks++; if (odst2 !== 2'd2) begin errors++; $display("FAIL single_dst got %0d expected 2", odst2); end
      checks++; if (oaddr2 !== 26'h0ABCDEF) begin errors++; $display("FAIL single_addr got %h expected 0abcdef", oaddr2); end
      checks++; if (opt2 !== 2'd1) begin errors++; $display("FAIL single_ptype got %0d expected 1", opt2); end
      #1;
      checks++; if (ch2 !== 1'b0) begin errors++; $display("FAIL single_ptr_wrap got %0d expected 0", ch2); end
      tick();
      checks++; if (oval2 !== 1'b0) begin errors++; $display("FAIL single_drain got %b expected 0", oval2); end
   endtask

   task automatic test_contention();
      logic [1:0]  exp_rdy;
      logic [25:0] exp_addr;
      dst2 = {2'd3, 2'd1}; addr2 = {26'h0000222, 26'h0000111}; pt2 = {2'd2, 2'd0};
      v2 = 2'b11; ordy2 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_rdy  = 2'b01 << (k % 2);
         exp_addr = (k % 2 == 1) ? 26'h0000222 : 26'h0000111;
         #1;
         checks++; if (rdy2 !== exp_rdy) begin errors++; $display("FAIL contention_grant%0d got %b expected %b", k, rdy2, exp_rdy); end
         tick();
         checks++; if (oval2 !== 1'b1 || osrc2 !== 2'(k % 2) || oaddr2 !== exp_addr)
            begin errors++; $display("FAIL contention_out%0d got v=%b src=%0d addr=%h expected v=1 src=%0d addr=%h", k, oval2, osrc2, oaddr2, k % 2, exp_addr); end
      end
   endtask

   task automatic test_backpressure();
      ordy2 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++; if (rdy2 !== 2'b00 || oval2 !== 1'b1 || osrc2 !== 2'd1 || oaddr2 !== 26'h0000222 || odst2 !== 2'd3)
            begin errors++; $display("FAIL stall%0d got rdy=%b v=%b src=%0d addr=%h expected rdy=00 v=1 src=1 addr=222", k, rdy2, oval2, osrc2, oaddr2); end
         tick();
      end
      ordy2 = 1'b1;
      #1;
      checks++; if (rdy2 !== 2'b01) begin errors++; $display("FAIL release_in_ready got %b expected 01", rdy2); end
      tick();
      v2 = 2'b00;
      checks++; if (oval2 !== 1'b1 || osrc2 !== 2'd0 || oaddr2 !== 26'h0000111 || opt2 !== 2'd0)
         begin errors++; $display("FAIL release_replace got v=%b src=%0d addr=%h expected v=1 src=0 addr=111", oval2, osrc2, oaddr2); end
   endtask

   task automatic test_idle();
      v2 = 2'b00; ordy2 = 1'b1;
      #1;
      checks++; if (ch2 !== 1'b1) begin errors++; $display("FAIL idle_chosen got %0d expected 1", ch2); end
      tick();
      checks++; if (oval2 !== 1'b0) begin errors++; $display("FAIL idle_drain got %b expected 0", oval2); end
      tick();
      checks++; if (oval2 !== 1'b0 || ch2 !== 1'b1) begin errors++; $display("FAIL idle_hold got v=%b ch=%0d expected v=0 ch=1", oval2, ch2); end
   endtask

   task automatic test_wrap();
      ordy4 = 1'b1;
      dst4[8:6] = 3'd5; addr4[77:52] = 26'h0000002; v4 = 4'b0100;
      #1;
      checks++; if (rdy4 !== 4'b0100) begin errors++; $display("FAIL wrap_setup_grant got %b expected 0100", rdy4); end
      tick();
      checks++; if (osrc4 !== 3'd3) begin errors++; $display("FAIL wrap_setup_src got %0d expected 3", osrc4); end
      dst4[11:9] = 3'd6; addr4[103:78] = 26'h0003333;
      dst4[2:0]  = 3'd7; addr4[25:0]   = 26'h0001000;
      v4 = 4'b1001;
      #1;
      checks++; if (ch4 !== 2'd3 || rdy4 !== 4'b1000) begin errors++; $display("FAIL wrap_grant3 got ch=%0d rdy=%b expected ch=3 rdy=1000", ch4, rdy4); end
      tick();
      checks++; if (osrc4 !== 3'd4 || odst4 !== 3'd6 || oaddr4 !== 26'h0003333)
         begin errors++; $display("FAIL wrap_out3 got src=%0d dst=%0d addr=%h expected src=4 dst=6 addr=3333", osrc4, odst4, oaddr4); end
      checks++; if (ch4 !== 2'd0 || rdy4 !== 4'b0001) begin errors++; $display("FAIL wrap_grant0 got ch=%0d rdy=%b expected ch=0 rdy=0001", ch4, rdy4); end
      tick();
      v4 = 4'b0000;
      checks++; if (osrc4 !== 3'd1 || odst4 !== 3'd7 || oaddr4 !== 26'h0001000)
         begin errors++; $display("FAIL wrap_out0 got src=%0d dst=%0d addr=%h expected src=1 dst=7 addr=1000", osrc4, odst4, oaddr4); end
   endtask

   task automatic test_reset_midflight();
      v2 = 2'b01; ordy2 = 1'b0;
      tick();
      checks++; if (oval2 !== 1'b1) begin errors++; $display("FAIL mid_fill got %b expected 1", oval2); end
      v2 = 2'b11;
      #3 reset = 1'b1;
      #1;
      checks++; if (oval2 !== 1'b0 || rdy2 !== 2'b00) begin errors++; $display("FAIL mid_reset got v=%b rdy=%b expected v=0 rdy=00", oval2, rdy2); end
      @(posedge clk); #1 reset = 1'b0;
      ordy2 = 1'b1;
      #1;
      checks++; if (ch2 !== 1'b0 || rdy2 !== 2'b01) begin errors++; $display("FAIL mid_first_grant got ch=%0d rdy=%b expected ch=0 rdy=01", ch2, rdy2); end
      tick();
      v2 = 2'b00;
      checks++; if (oval2 !== 1'b1 || osrc2 !== 2'd0 || oaddr2 !== 26'h0000111)
         begin errors++; $display("FAIL mid_after got v=%b src=%0d addr=%h expected v=1 src=0 addr=111", oval2, osrc2, oaddr2); end
   endtask

   initial begin
      v2 = '0; dst2 = '0; addr2 = '0; pt2 = '0; ordy2 = 1'b0;
      v4 = '0; dst4 = '0; addr4 = '0; pt4 = '0; ordy4 = 1'b1;
      #2;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_idle();
      test_wrap();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
